// File: rtl/pipelined_ripple_adder_if.sv
// Handshake bundle for pipelined_ripple_adder: operation request side and result side.
interface pipelined_ripple_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer of operations / consumer of results.
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor. The carry chain is cut into CHUNK-bit segments,
// one segment resolved per stage, with the inter-segment carry registered between stages.
// Valid/ready backpressure on both sides; results leave in acceptance order.
module pipelined_ripple_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_ripple_adder_if.slave     bus
);
    localparam int unsigned STAGES = WIDTH / CHUNK;

    // Per-stage state: partial sum (chunks 0..i resolved), carry into chunk i+1,
    // the full operands (upper chunks still needed downstream) and the sign bits for ovf.
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] sa_q;
    logic [STAGES-1:0] sb_q;
    logic [WIDTH-1:0]  psum_q [STAGES];
    logic [WIDTH-1:0]  opa_q  [STAGES];
    logic [WIDTH-1:0]  opb_q  [STAGES];

    // Stage inputs and next-state values.
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [CHUNK:0]    chunk_res [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_sa;
    logic [STAGES-1:0] src_sb;
    logic [STAGES-1:0] ready;
    logic [STAGES-1:0] load;
    logic              ready_acc;

    logic [WIDTH-1:0]  b_eff;
    logic              c0;

    // Subtraction is a + ~b + 1, so cin is forced to 1 and ignored.
    assign b_eff = bus.sub ? ~bus.b : bus.b;
    assign c0    = bus.sub | bus.cin;

    // Stage i can take a new entry when it or any stage downstream is empty, or the output drains.
    always_comb begin
        ready     = '0;
        ready_acc = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            ready_acc = ready_acc | ~vld_q[i];
            ready[i]  = ready_acc;
        end
    end

    // Route each stage's source: S0 from the input port, Si from Si-1's registers.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            src_a[i]   = '0;
            src_b[i]   = '0;
            src_sum[i] = '0;
        end
        src_c  = '0;
        src_sa = '0;
        src_sb = '0;
        load   = '0;
        src_a[0]  = bus.a;
        src_b[0]  = b_eff;
        src_c[0]  = c0;
        src_sa[0] = bus.a[WIDTH-1];
        src_sb[0] = b_eff[WIDTH-1];
        load[0]   = bus.in_valid & ready[0];
        for (int i = 1; i < STAGES; i++) begin
            src_a[i]   = opa_q[i-1];
            src_b[i]   = opb_q[i-1];
            src_sum[i] = psum_q[i-1];
            src_c[i]   = carry_q[i-1];
            src_sa[i]  = sa_q[i-1];
            src_sb[i]  = sb_q[i-1];
            load[i]    = vld_q[i-1] & ready[i];
        end
    end

    // Each stage resolves exactly its own chunk; lower chunks pass through untouched.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            chunk_res[i] = {1'b0, src_a[i][i*CHUNK +: CHUNK]}
                         + {1'b0, src_b[i][i*CHUNK +: CHUNK]}
                         + {{CHUNK{1'b0}}, src_c[i]};
            sum_d[i] = src_sum[i];
            sum_d[i][i*CHUNK +: CHUNK] = chunk_res[i][CHUNK-1:0];
        end
    end

    // Stage registers; a stage whose entry moves on without a replacement goes empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            carry_q <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            for (int i = 0; i < STAGES; i++) begin
                psum_q[i] <= '0;
                opa_q[i]  <= '0;
                opb_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (ready[i]) begin
                    vld_q[i] <= load[i];
                end
                if (load[i]) begin
                    psum_q[i]  <= sum_d[i];
                    carry_q[i] <= chunk_res[i][CHUNK];
                    opa_q[i]   <= src_a[i];
                    opb_q[i]   <= src_b[i];
                    sa_q[i]    <= src_sa[i];
                    sb_q[i]    <= src_sb[i];
                end
            end
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.sum       = psum_q[STAGES-1];
    assign bus.cout      = carry_q[STAGES-1];
    assign bus.ovf       = (sa_q[STAGES-1] == sb_q[STAGES-1])
                         && (psum_q[STAGES-1][WIDTH-1] != sa_q[STAGES-1]);
endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder: a 16/4 instance for arithmetic, latency,
// throughput, backpressure and reset, plus a 4/1 instance streamed with every a,b,cin combo.
module tb_pipelined_ripple_adder;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   acc;

    pipelined_ripple_adder_if #(.WIDTH(16)) bus16 ();
    pipelined_ripple_adder_if #(.WIDTH(4))  bus4 ();

    pipelined_ripple_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    pipelined_ripple_adder #(.WIDTH(4), .CHUNK(1)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One op into an empty 16/4 pipe with out_ready=1; checks latency and the result.
    task automatic send_check(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic sub, input logic [15:0] es,
                              input logic ec, input logic eo);
        bus16.a        = a;
        bus16.b        = b;
        bus16.cin      = cin;
        bus16.sub      = sub;
        bus16.in_valid = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(bus16.in_ready), 32'd1);
        step();
        bus16.in_valid = 1'b0;
        step();
        step();
        chk({tag, ".early"}, 32'(bus16.out_valid), 32'd0);
        step();
        chk({tag, ".valid"}, 32'(bus16.out_valid), 32'd1);
        chk({tag, ".sum"}, 32'(bus16.sum), 32'(es));
        chk({tag, ".cout"}, 32'(bus16.cout), 32'(ec));
        chk({tag, ".ovf"}, 32'(bus16.ovf), 32'(eo));
        step();
        chk({tag, ".drained"}, 32'(bus16.out_valid), 32'd0);
    endtask

    // Throughput vectors (sub=0, cin=0) with hand-computed results.
    logic [15:0] tp_a  [6] = '{16'h0001, 16'h0F0F, 16'hFFFF, 16'h8000, 16'hABCD, 16'h1111};
    logic [15:0] tp_b  [6] = '{16'h0002, 16'h00F1, 16'hFFFF, 16'h8000, 16'h1234, 16'hEEEF};
    logic [15:0] tp_s  [6] = '{16'h0003, 16'h1000, 16'hFFFE, 16'h0000, 16'hBE01, 16'h0000};
    logic        tp_c  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        tp_o  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [8:0] v;
        logic [4:0] e;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus16.sub = 1'b0; bus16.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus4.sub = 1'b0; bus4.out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst.out_valid", 32'(bus16.out_valid), 32'd0);
        chk("rst.sum", 32'(bus16.sum), 32'd0);
        chk("rst.cout", 32'(bus16.cout), 32'd0);
        chk("rst.ovf", 32'(bus16.ovf), 32'd0);
        chk("rst.in_ready", 32'(bus16.in_ready), 32'd1);
        chk("rst.out_valid4", 32'(bus4.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed arithmetic
        send_check("add_ff_1", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        send_check("ripple_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_check("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_check("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send_check("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send_check("sub_cin0", 16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
        send_check("add_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

        // Back-to-back stream: one result per cycle, 4-cycle latency, in order
        for (int c = 0; c < 10; c++) begin
            chk("tp.in_ready", 32'(bus16.in_ready), 32'd1);
            chk("tp.valid", 32'(bus16.out_valid), 32'((c >= 4) ? 1 : 0));
            if (c >= 4) begin
                chk("tp.sum", 32'(bus16.sum), 32'(tp_s[c-4]));
                chk("tp.cout", 32'(bus16.cout), 32'(tp_c[c-4]));
                chk("tp.ovf", 32'(bus16.ovf), 32'(tp_o[c-4]));
            end
            if (c < 6) begin
                bus16.a = tp_a[c]; bus16.b = tp_b[c]; bus16.cin = 1'b0; bus16.sub = 1'b0;
                bus16.in_valid = 1'b1;
            end else begin
                bus16.in_valid = 1'b0;
            end
            step();
        end

        // Backpressure: source holds its op until accepted
        bus16.out_ready = 1'b0;
        bus16.b = 16'h0100;
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            bus16.a = 16'(16'h0010 + acc);
            bus16.in_valid = 1'b1;
            #1;
            if (k >= 4) begin
                chk("bp.stable_valid", 32'(bus16.out_valid), 32'd1);
                chk("bp.stable_sum", 32'(bus16.sum), 32'h0110);
                chk("bp.blocked", 32'(bus16.in_ready), 32'd0);
            end
            if (bus16.in_ready) acc++;
            step();
        end
        chk("bp.accepted", 32'(acc), 32'd4);
        bus16.in_valid = 1'b0;
        bus16.out_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            chk("bp.drain_valid", 32'(bus16.out_valid), 32'd1);
            chk("bp.drain_sum", 32'(bus16.sum), 32'(16'h0110 + j));
            step();
        end
        chk("bp.empty", 32'(bus16.out_valid), 32'd0);
        send_check("bp.resume", 16'h0F00, 16'h00F0, 1'b1, 1'b0, 16'h0FF1, 1'b0, 1'b0);

        // Exhaustive 4-bit stream through the CHUNK=1 instance
        for (int c = 0; c < 516; c++) begin
            if (c >= 4) begin
                v = 9'(c - 4);
                e = {1'b0, v[8:5]} + {1'b0, v[4:1]} + {4'b0, v[0]};
                chk("w4.valid", 32'(bus4.out_valid), 32'd1);
                chk("w4.sum", {27'd0, bus4.cout, bus4.sum}, {27'd0, e});
                chk("w4.ovf", 32'(bus4.ovf),
                    32'((v[8] == v[4]) && (e[3] != v[8])));
            end else begin
                chk("w4.fill", 32'(bus4.out_valid), 32'd0);
            end
            if (c < 512) begin
                v = 9'(c);
                bus4.a = v[8:5]; bus4.b = v[4:1]; bus4.cin = v[0];
                bus4.in_valid = 1'b1;
            end else begin
                bus4.in_valid = 1'b0;
            end
            step();
        end
        step();
        chk("w4.done", 32'(bus4.out_valid), 32'd0);

        // Reset mid-flight: results held at output, then async reset between edges
        bus16.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus16.a = 16'(16'h1000 + k); bus16.b = 16'h0234; bus16.cin = 1'b0;
            bus16.sub = 1'b0; bus16.in_valid = 1'b1;
            step();
        end
        bus16.in_valid = 1'b0;
        step();
        chk("mr.pre_valid", 32'(bus16.out_valid), 32'd1);
        chk("mr.pre_sum", 32'(bus16.sum), 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr.valid", 32'(bus16.out_valid), 32'd0);
        chk("mr.sum", 32'(bus16.sum), 32'd0);
        chk("mr.in_ready", 32'(bus16.in_ready), 32'd1);
        step();
        rst_n = 1'b1;
        bus16.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("mr.no_stale", 32'(bus16.out_valid), 32'd0);
            chk("mr.ready", 32'(bus16.in_ready), 32'd1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined successor to the team's 4-bit ripple-carry adder. It adds (or subtracts) two WIDTH-bit operands by splitting the carry chain into CHUNK-bit ripple segments, one segment per pipeline stage, with the inter-segment carry registered. A valid/ready handshake on both sides provides backpressure. It sits in datapaths that need wide adds at full clock rate, accepting one operation per cycle.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per stage; STAGES = WIDTH/CHUNK (≥1), derived, not overridable.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. Asynchronous, active-low.
- in_valid  input  1  operation present on a/b/cin/sub.
- in_ready  output  1  block accepts this cycle; transfer when in_valid && in_ready at a rising edge.
- a  input  WIDTH  operand A (two's complement for ovf purposes).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a+~b+1 (a−b).
- out_valid  output  1  result on sum/cout/ovf is valid.
- out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
- sum  output  WIDTH  result, mod 2^WIDTH.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow: a[MSB] == b_eff[MSB] and sum[MSB] != a[MSB], b_eff = sub ? ~b : b.

## Operation
- STAGES register stages S0..S(STAGES−1), each with a valid bit, partial sum (chunks 0..i resolved), carry into next chunk, and the unresolved upper operand chunks, plus sign bits a[MSB], b_eff[MSB].
- S0 loads chunk 0 = a[CHUNK−1:0] + b_eff[CHUNK−1:0] + c0, c0 = sub ? 1 : cin.
- Si (i≥1) loads chunk i from Si−1's stored operand chunk i plus Si−1's registered carry; earlier chunks pass through unchanged.
- Output registers are those of S(STAGES−1); ovf computed from stored sign bits and final sum[MSB].
- Flow control per stage: Si advances when Si+1 is empty or advancing; last stage advances when !out_valid or out_ready. in_ready = !S0.valid or S0 advancing (combinational from out_ready through the chain; no combinational path from in_valid).
- Results emerge strictly in acceptance order; no drop, no duplication.

## Timing
- Reset (rst_n low, asynchronous): all stage valid bits 0, sum=0, cout=0, ovf=0, out_valid=0 immediately; in_ready=1 once rst_n high and while low. In-flight operations are discarded; none emitted after release.
- Latency: operation accepted at edge E appears with out_valid=1 after edge E+(STAGES−1); i.e. STAGES cycles. STAGES=1 degenerates to a registered full-width ripple adder, 1-cycle latency.
- Throughput: 1 op/cycle with out_ready held 1.
- Stall: while out_valid && !out_ready, sum/cout/ovf/out_valid stay stable. Pipeline holds up to STAGES ops; when all stages full and out_ready=0, in_ready=0.
- Simultaneous: full pipeline with out_ready=1 accepts a new op in the same cycle (in_ready=1).
- Carry/width: exact mod-2^WIDTH arithmetic; cout is the (WIDTH+1)-th bit; no saturation.

## Test plan
- WIDTH=16,CHUNK=4: a=0x00FF,b=0x0001,cin=0,sub=0 -> after 4 cycles sum=0x0100,cout=0,ovf=0.
- Full-chain ripple: a=0xFFFF,b=0x0000,cin=1 -> sum=0x0000,cout=1,ovf=0; a=0x7FFF,b=0x0001 -> sum=0x8000,ovf=1,cout=0.
- Subtract: a=0x8000,b=0x0001,sub=1,cin=1 (ignored) -> sum=0x7FFF,cout=1,ovf=1; a=0x0003,b=0x0005,sub=1 -> sum=0xFFFE,cout=0,ovf=0.
- WIDTH=4,CHUNK=1, out_ready=1: stream all 512 combos of a,b,cin back-to-back (sub=0) -> one result/cycle, matches a+b+cin, latency 4, in order.
- Backpressure (16/4): out_ready=0 while in_valid=1 for 10 cycles -> exactly 4 accepted, in_ready=0 thereafter, outputs stable; raise out_ready -> 4 results drain in order, then normal flow resumes.
- Reset mid-flight: 3 ops in flight, pull rst_n low mid-cycle -> out_valid=0,sum=0 without clock edge; after release, no stale result ever appears, in_ready=1.
